// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-side request responder.
package mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } memctl_state_t;

  localparam int unsigned LAT_DEFAULT = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Access-latency counter: clear has priority over enable; done flags cnt == LAT-1.
module mem_lat_counter #(
  parameter int unsigned LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 4'(LAT - 1));

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory-side responder: serves dcache (priority) and icache requests on a fixed-latency RAM.
// Defining MEMCTL_STATS_EN adds the dacc_cnt / istall_cnt statistics outputs.
module mem_resp_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] iload,
  output logic          iwait,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic [DW-1:0] dload,
  output logic          dwait,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload
`ifdef MEMCTL_STATS_EN
  ,
  output logic [31:0]   dacc_cnt,
  output logic [31:0]   istall_cnt
`endif
);

  memctl_state_t state_q, state_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          iwait_q, iwait_d, dwait_q, dwait_d;
  logic [DW-1:0] iload_q, iload_d, dload_q, dload_d;
  logic          cnt_clr, cnt_en, cnt_done;

  mem_lat_counter #(.LAT(LAT)) u_lat_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .clear (cnt_clr),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  // Waits/loads are registered, so the completion shows the cycle after cnt==LAT-1;
  // IDLE skips arbitration during that cycle so the still-held request is not re-served.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    iwait_d    = 1'b1;
    dwait_d    = 1'b1;
    iload_d    = '0;
    dload_d    = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    unique case (state_q)
      IDLE: begin
        if (iwait_q && dwait_q) begin
          if (dREN || dWEN) begin
            state_d    = DACC;
            req_addr_d = daddr;
            cnt_clr    = 1'b1;
          end else if (iREN) begin
            state_d    = IACC;
            req_addr_d = iaddr;
            cnt_clr    = 1'b1;
          end
        end
      end
      DACC: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          state_d = IDLE;
        end else if (daddr != req_addr_q) begin
          req_addr_d = daddr;
          cnt_clr    = 1'b1;
        end else if (cnt_done) begin
          dwait_d = 1'b0;
          dload_d = ramload;
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (iaddr != req_addr_q) begin
          req_addr_d = iaddr;
          cnt_clr    = 1'b1;
        end else if (cnt_done) begin
          iwait_d = 1'b0;
          iload_d = ramload;
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      iwait_q    <= 1'b1;
      dwait_q    <= 1'b1;
      iload_q    <= '0;
      dload_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      iwait_q    <= iwait_d;
      dwait_q    <= dwait_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
    end
  end

  assign iwait = iwait_q;
  assign dwait = dwait_q;
  assign iload = iload_q;
  assign dload = dload_q;

`ifdef MEMCTL_STATS_EN
  logic [31:0] dacc_cnt_q, dacc_cnt_d, istall_cnt_q, istall_cnt_d;

  always_comb begin
    dacc_cnt_d   = dacc_cnt_q;
    istall_cnt_d = istall_cnt_q;
    if (!dwait_d && (dacc_cnt_q != '1)) begin
      dacc_cnt_d = dacc_cnt_q + 32'd1;
    end
    if (iREN && iwait_q && (istall_cnt_q != '1)) begin
      istall_cnt_d = istall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dacc_cnt_q   <= '0;
      istall_cnt_q <= '0;
    end else begin
      dacc_cnt_q   <= dacc_cnt_d;
      istall_cnt_q <= istall_cnt_d;
    end
  end

  assign dacc_cnt   = dacc_cnt_q;
  assign istall_cnt = istall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Bench for mem_resp_ctrl: timestamp-based access model, environment RAM, directed and random traffic.
module tb_mem_resp_ctrl;
  import mem_pkg::*;

  localparam int unsigned LAT  = 4;
  localparam int unsigned NRND = 4000;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN;
  addr_t iaddr, daddr, ramaddr;
  word_t iload, dload, dstore, ramstore, ramload;
`ifdef MEMCTL_STATS_EN
  logic [31:0] dacc_cnt, istall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  word_t ram [addr_t];
  word_t exp_mem [addr_t];

  mem_resp_ctrl #(.LAT(LAT), .AW(32), .DW(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload)
`ifdef MEMCTL_STATS_EN
    , .dacc_cnt(dacc_cnt), .istall_cnt(istall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic word_t dflt(input addr_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic word_t ram_rd(input addr_t a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic word_t exp_rd(input addr_t a);
    return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM read data presented once the address has settled for the cycle.
  initial ramload = '0;
  always @(posedge CLK) begin
    #2;
    ramload = ram_rd(ramaddr);
  end

  // Model: an access latched at cycle c shows its wait-low cycle at c+LAT+1 unless dropped or re-addressed.
  int          m_acc = 0;
  addr_t       m_addr;
  longint      m_end;
  int          r_kind = 0;
  longint      r_cyc = -1;
  word_t       r_data;
  bit          r_wr;
  longint      cyc = 0;
  int unsigned wr_run = 0;
  addr_t       wr_addr;
  bit          d_rsp, i_rsp, e_ren, e_wen;
  addr_t       e_addr;
  word_t       e_store;

  always @(negedge CLK) begin
    if (!nRST) begin
      m_acc  = 0;
      r_kind = 0;
      r_cyc  = -1;
      wr_run = 0;
      chk("rst_dwait", {31'd0, dwait}, 32'd1);
      chk("rst_iwait", {31'd0, iwait}, 32'd1);
      chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    end else begin
      d_rsp = (r_kind == 1) && (r_cyc == cyc);
      i_rsp = (r_kind == 2) && (r_cyc == cyc);
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      if (m_acc == 1) begin
        e_wen = dWEN; e_ren = dREN & ~dWEN; e_addr = daddr; e_store = dstore;
      end else if (m_acc == 2) begin
        e_ren = 1'b1; e_addr = iaddr;
      end
      chk("dwait", {31'd0, dwait}, {31'd0, !d_rsp});
      chk("iwait", {31'd0, iwait}, {31'd0, !i_rsp});
      if (!(d_rsp && r_wr)) chk("dload", dload, d_rsp ? r_data : 32'd0);
      chk("iload", iload, i_rsp ? r_data : 32'd0);
      chk("ramREN", {31'd0, ramREN}, {31'd0, e_ren});
      chk("ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);

      // Environment RAM commits a write held on one address for LAT consecutive cycles.
      if (ramWEN) begin
        if (wr_run != 0 && ramaddr == wr_addr) wr_run++;
        else begin wr_run = 1; wr_addr = ramaddr; end
        if (wr_run == LAT) ram[ramaddr] = ramstore;
      end else begin
        wr_run = 0;
      end

      if (m_acc == 0) begin
        if (r_cyc != cyc) begin
          if (dREN || dWEN) begin
            m_acc = 1; m_addr = daddr; m_end = cyc + LAT + 1;
          end else if (iREN) begin
            m_acc = 2; m_addr = iaddr; m_end = cyc + LAT + 1;
          end
        end
      end else if (m_acc == 1) begin
        if (!(dREN || dWEN)) m_acc = 0;
        else if (daddr != m_addr) begin m_addr = daddr; m_end = cyc + LAT + 1; end
        else if (m_end == cyc + 1) begin
          r_kind = 1; r_cyc = cyc + 1; r_wr = dWEN; r_data = exp_rd(m_addr);
          if (dWEN) exp_mem[m_addr] = dstore;
          m_acc = 0;
        end
      end else begin
        if (!iREN) m_acc = 0;
        else if (iaddr != m_addr) begin m_addr = iaddr; m_end = cyc + LAT + 1; end
        else if (m_end == cyc + 1) begin
          r_kind = 2; r_cyc = cyc + 1; r_wr = 1'b0; r_data = exp_rd(m_addr);
          m_acc = 0;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle2();
    dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    tick(); tick();
  endtask

  function automatic addr_t pick_addr();
    return 32'h100 + 32'(($urandom % 8) << 2);
  endfunction

  bit d_busy, d_seen, i_busy, i_seen;
  int r;

  initial begin
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram[32'h100] = 32'hDEADBEEF;  exp_mem[32'h100] = 32'hDEADBEEF;
    ram[32'h104] = 32'h0BADF00D;  exp_mem[32'h104] = 32'h0BADF00D;
    ram[32'h300] = 32'hCAFEF00D;  exp_mem[32'h300] = 32'hCAFEF00D;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_iwait", {31'd0, iwait}, 32'd1);
    chk("reset_dwait", {31'd0, dwait}, 32'd1);
    chk("reset_ramaddr", ramaddr, 32'd0);
    chk("reset_ramstore", ramstore, 32'd0);
    chk("reset_dload", dload, 32'd0);
    chk("reset_iload", iload, 32'd0);
    nRST = 1'b1;
    idle2();

    // Read 0x100: wait low exactly at cycle 5.
    dREN = 1'b1; daddr = 32'h100;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) dREN = 1'b0;
      #3;
      chk("rd_dwait", {31'd0, dwait}, (k == 5) ? 32'd0 : 32'd1);
      if (k == 5) chk("rd_dload", dload, 32'hDEADBEEF);
      tick();
    end
    idle2();

    // Write 0x200 then read it back.
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) dWEN = 1'b0;
      #3;
      chk("wr_ramWEN", {31'd0, ramWEN}, (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      chk("wr_dwait", {31'd0, dwait}, (k == 5) ? 32'd0 : 32'd1);
      tick();
    end
    idle2();
    dREN = 1'b1; daddr = 32'h200;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) dREN = 1'b0;
      #3;
      if (k == 5) chk("wrrd_dload", dload, 32'h12345678);
      tick();
    end
    idle2();

    // Simultaneous D and I: D first, I completes at cycle 11.
    dREN = 1'b1; daddr = 32'h104; iREN = 1'b1; iaddr = 32'h300;
    for (int k = 0; k <= 12; k++) begin
      if (k == 6) dREN = 1'b0;
      if (k == 12) iREN = 1'b0;
      #3;
      chk("arb_dwait", {31'd0, dwait}, (k == 5) ? 32'd0 : 32'd1);
      chk("arb_iwait", {31'd0, iwait}, (k == 11) ? 32'd0 : 32'd1);
      if (k == 5) chk("arb_dload", dload, 32'h0BADF00D);
      if (k == 11) chk("arb_iload", iload, 32'hCAFEF00D);
      tick();
    end
    idle2();

    // D abort at cnt=1, then a full-latency I access.
    dREN = 1'b1; daddr = 32'h100;
    for (int k = 0; k <= 9; k++) begin
      if (k == 2) dREN = 1'b0;
      if (k == 3) begin iREN = 1'b1; iaddr = 32'h300; end
      if (k == 9) iREN = 1'b0;
      #3;
      chk("abort_dwait", {31'd0, dwait}, 32'd1);
      chk("abort_iwait", {31'd0, iwait}, (k == 8) ? 32'd0 : 32'd1);
      tick();
    end
    idle2();

    // Address change at cnt=2 restarts the access.
    dREN = 1'b1; daddr = 32'h100;
    for (int k = 0; k <= 9; k++) begin
      if (k == 3) daddr = 32'h104;
      if (k == 9) dREN = 1'b0;
      #3;
      chk("chg_dwait", {31'd0, dwait}, (k == 8) ? 32'd0 : 32'd1);
      if (k == 8) chk("chg_dload", dload, 32'h0BADF00D);
      tick();
    end
    idle2();

    // Reset during a write at cnt=2: nothing may be committed.
    dWEN = 1'b1; daddr = 32'h204; dstore = 32'h55AA55AA;
    tick(); tick(); tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("rstmid_dwait", {31'd0, dwait}, 32'd1);
    chk("rstmid_ramWEN", {31'd0, ramWEN}, 32'd0);
    dWEN = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    #3;
    chk("rstrel_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rstrel_ramREN", {31'd0, ramREN}, 32'd0);
    tick();
    dREN = 1'b1; daddr = 32'h204;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) dREN = 1'b0;
      #3;
      if (k == 5) chk("rstrd_dload", dload, 32'h5A5A0204);
      tick();
    end
    idle2();

    // Random traffic from protocol-following cache agents.
    d_busy = 0; d_seen = 0; i_busy = 0; i_seen = 0;
    for (int c = 0; c < NRND; c++) begin
      if (d_busy) begin
        if (d_seen) d_busy = 0;
        else if ($urandom % 40 == 0) d_busy = 0;
        else if (!dWEN && ($urandom % 30 == 0)) daddr = pick_addr();
      end
      if (!d_busy && ($urandom % 3 == 0)) begin
        d_busy = 1;
        r = int'($urandom % 4);
        dREN = (r != 2); dWEN = (r >= 2);
        daddr = pick_addr(); dstore = $urandom;
      end
      if (!d_busy) begin dREN = 1'b0; dWEN = 1'b0; end
      if (i_busy) begin
        if (i_seen) i_busy = 0;
        else if ($urandom % 40 == 0) i_busy = 0;
        else if ($urandom % 30 == 0) iaddr = pick_addr();
      end
      if (!i_busy && ($urandom % 2 == 0)) begin
        i_busy = 1; iaddr = pick_addr();
      end
      iREN = i_busy;
      #3;
      d_seen = (dwait == 1'b0);
      i_seen = (iwait == 1'b0);
      tick();
    end
    idle2();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
